// File: rtl/breakout_pkg.sv
// Shared definitions for the brick alive-bit store and its arbiter.
package breakout_pkg;

    // Default number of bricks tracked on the playfield.
    localparam int NUM_BLOCKS_DEF = 96;

    // Default brick address width (covers up to 128 bricks).
    localparam int ADDR_W_DEF = 7;

    // Arbiter states: SWEEP rewrites every brick alive; IDLE serves the clients.
    typedef enum logic [0:0] {
        ST_SWEEP = 1'b0,
        ST_IDLE  = 1'b1
    } arb_state_e;

    // Reports whether a brick address falls inside the tracked range.
    function automatic logic addr_in_range(input logic [7:0] addr, input int depth);
        logic in_range;
        if (int'(addr) < depth) begin
            in_range = 1'b1;
        end else begin
            in_range = 1'b0;
        end
        return in_range;
    endfunction

endpackage

// File: rtl/block_alive_mem.sv
// Single-port alive-bit store: one access per cycle, registered read data.
// A write returns the previous contents on its read port (read-before-write),
// which is how the physics client learns the brick state before its kill.
// Addresses outside the tracked range read as 0 and ignore writes.
module block_alive_mem
    import breakout_pkg::*;
#(
    parameter int DEPTH  = NUM_BLOCKS_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wdata,
    output logic              rdata
);

    logic mem_r [DEPTH];
    logic rdata_r;
    logic in_range_s;

    assign in_range_s = addr_in_range(8'(addr), DEPTH);
    assign rdata      = rdata_r;

    // Storage array; contents are defined by the arbiter's sweep, not by reset.
    always_ff @(posedge clk) begin
        if (en && we && in_range_s) begin
            mem_r[addr] <= wdata;
        end
    end

    // Read register: captures the pre-access value of the addressed brick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= 1'b0;
        end else if (en) begin
            if (in_range_s) begin
                rdata_r <= mem_r[addr];
            end else begin
                rdata_r <= 1'b0;
            end
        end else begin
            rdata_r <= rdata_r;
        end
    end

endmodule

// File: rtl/block_ram_arbiter.sv
// Arbitrates the single alive-bit port between the init sweep, the renderer
// and the physics engine (priority in that order), and tracks the number of
// bricks still alive.
module block_ram_arbiter
    import breakout_pkg::*;
#(
    parameter int NUM_BLOCKS = NUM_BLOCKS_DEF,
    parameter int ADDR_W     = ADDR_W_DEF
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              R_EN,
    input  logic [ADDR_W-1:0] R_ADDR,
    output logic              R_ALIVE,
    input  logic              P_REQ,
    input  logic              P_WE,
    input  logic [ADDR_W-1:0] P_ADDR,
    output logic              P_GNT,
    output logic              P_VALID,
    output logic              P_ALIVE,
    input  logic              INIT_REQ,
    output logic              BUSY,
    output logic [ADDR_W:0]   ALIVE_COUNT,
    output logic              LEVEL_CLEAR
);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_BLOCKS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   COUNT_FULL = (ADDR_W + 1)'(NUM_BLOCKS);
    localparam logic [ADDR_W:0]   COUNT_ZERO = (ADDR_W + 1)'(0);
    localparam logic [ADDR_W:0]   COUNT_ONE  = (ADDR_W + 1)'(1);

    arb_state_e        state_r;
    arb_state_e        state_nxt_s;
    logic [ADDR_W-1:0] sweep_addr_r;
    logic [ADDR_W-1:0] sweep_addr_nxt_s;
    logic              sweep_done_s;

    logic              mem_en_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic              mem_wdata_s;
    logic              mem_rdata_s;

    logic              p_gnt_s;
    logic              rd_issue_s;
    logic              rd_zero_s;

    logic              rd_pend_r;
    logic              rd_zero_r;
    logic              r_hold_r;
    logic              r_alive_s;
    logic              p_valid_r;
    logic              p_kill_r;
    logic              kill_hit_s;
    logic [ADDR_W:0]   count_r;

    block_alive_mem #(
        .DEPTH  (NUM_BLOCKS),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (CLK),
        .rst_n (RESET_N),
        .en    (mem_en_s),
        .we    (mem_we_s),
        .addr  (mem_addr_s),
        .wdata (mem_wdata_s),
        .rdata (mem_rdata_s)
    );

    // Next-state, port steering and grant decision for the current cycle.
    always_comb begin
        state_nxt_s      = state_r;
        sweep_addr_nxt_s = sweep_addr_r;
        sweep_done_s     = 1'b0;
        mem_en_s         = 1'b0;
        mem_we_s         = 1'b0;
        mem_addr_s       = ADDR_ZERO;
        mem_wdata_s      = 1'b0;
        p_gnt_s          = 1'b0;
        rd_issue_s       = 1'b0;
        rd_zero_s        = 1'b0;
        case (state_r)
            ST_SWEEP: begin
                // Sweep owns the port; a renderer read in this window returns 0.
                mem_en_s    = 1'b1;
                mem_we_s    = 1'b1;
                mem_addr_s  = sweep_addr_r;
                mem_wdata_s = 1'b1;
                rd_issue_s  = R_EN;
                rd_zero_s   = 1'b1;
                if (INIT_REQ) begin
                    sweep_addr_nxt_s = ADDR_ZERO;
                end else if (sweep_addr_r == LAST_ADDR) begin
                    sweep_done_s     = 1'b1;
                    state_nxt_s      = ST_IDLE;
                    sweep_addr_nxt_s = ADDR_ZERO;
                end else begin
                    sweep_addr_nxt_s = sweep_addr_r + ADDR_ONE;
                end
            end
            ST_IDLE: begin
                if (R_EN) begin
                    mem_en_s   = 1'b1;
                    mem_addr_s = R_ADDR;
                    rd_issue_s = 1'b1;
                end else if (P_REQ && !INIT_REQ) begin
                    // Physics kill writes 0; a read-only op just samples.
                    mem_en_s    = 1'b1;
                    mem_we_s    = P_WE;
                    mem_addr_s  = P_ADDR;
                    mem_wdata_s = 1'b0;
                    p_gnt_s     = 1'b1;
                end else begin
                    mem_en_s = 1'b0;
                end
                if (INIT_REQ) begin
                    state_nxt_s      = ST_SWEEP;
                    sweep_addr_nxt_s = ADDR_ZERO;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s      = ST_SWEEP;
                sweep_addr_nxt_s = ADDR_ZERO;
            end
        endcase
    end

    // FSM state and sweep pointer.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r      <= ST_SWEEP;
            sweep_addr_r <= ADDR_ZERO;
        end else begin
            state_r      <= state_nxt_s;
            sweep_addr_r <= sweep_addr_nxt_s;
        end
    end

    // Pipeline flags tracking which client owns the read data next cycle.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_pend_r <= 1'b0;
            rd_zero_r <= 1'b0;
            r_hold_r  <= 1'b0;
            p_valid_r <= 1'b0;
            p_kill_r  <= 1'b0;
        end else begin
            rd_pend_r <= rd_issue_s;
            rd_zero_r <= rd_zero_s;
            r_hold_r  <= r_alive_s;
            p_valid_r <= p_gnt_s;
            p_kill_r  <= p_gnt_s & P_WE;
        end
    end

    // Committed alive count: full after a sweep, minus one per effective kill.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            count_r <= COUNT_ZERO;
        end else if (sweep_done_s) begin
            count_r <= COUNT_FULL;
        end else if (kill_hit_s) begin
            count_r <= count_r - COUNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    // A kill only counts if the pre-access bit (now on the read port) was alive,
    // so the decrement is visible in the same cycle as P_VALID.
    assign kill_hit_s  = p_valid_r & p_kill_r & mem_rdata_s;
    assign r_alive_s   = rd_pend_r ? (mem_rdata_s & ~rd_zero_r) : r_hold_r;

    assign R_ALIVE     = r_alive_s;
    assign P_GNT       = p_gnt_s;
    assign P_VALID     = p_valid_r;
    assign P_ALIVE     = p_valid_r & mem_rdata_s;
    assign BUSY        = (state_r == ST_SWEEP);
    assign ALIVE_COUNT = kill_hit_s ? (count_r - COUNT_ONE) : count_r;
    assign LEVEL_CLEAR = kill_hit_s & (count_r == COUNT_ONE);

endmodule

// File: doc/block_ram_arbiter.md
BLOCK_RAM_ARBITER -- requirements
Module: block_ram_arbiter

Interface
REQ-001 Parameter NUM_BLOCKS, default 96, number of live-tracked bricks (1..128).
REQ-002 Parameter ADDR_W, default 7, brick address width.
REQ-003 CLK  in  1  single system clock; all state on rising edge.
REQ-004 RESET_N  in  1  reset, asynchronous, active-low.
REQ-005 R_EN  in  1  renderer read strobe.
REQ-006 R_ADDR  in  ADDR_W  renderer brick address.
REQ-007 R_ALIVE  out  1  renderer read data, valid the cycle after R_EN.
REQ-008 P_REQ  in  1  physics access request; held until granted.
REQ-009 P_WE  in  1  physics op: 1 = kill brick, 0 = read only.
REQ-010 P_ADDR  in  ADDR_W  physics brick address.
REQ-011 P_GNT  out  1  one-cycle pulse, physics access performed this cycle.
REQ-012 P_VALID  out  1  one-cycle pulse, cycle after P_GNT.
REQ-013 P_ALIVE  out  1  pre-access alive bit of granted address, valid with P_VALID.
REQ-014 INIT_REQ  in  1  one-cycle pulse, restore all bricks (new level/game).
REQ-015 BUSY  out  1  high while init sweep runs.
REQ-016 ALIVE_COUNT  out  ADDR_W+1  number of alive bricks.
REQ-017 LEVEL_CLEAR  out  1  one-cycle pulse when ALIVE_COUNT falls to 0.

Function
REQ-018 Storage SHALL hold one alive bit per brick with exactly one access (read or write) per cycle.
REQ-019 FSM states SHALL be SWEEP and IDLE; SWEEP entered after reset release or INIT_REQ, IDLE entered after address NUM_BLOCKS-1 is written.
REQ-020 SWEEP SHALL write alive=1 to addresses 0..NUM_BLOCKS-1, one per cycle, ascending; ALIVE_COUNT = NUM_BLOCKS on the cycle IDLE is entered.
REQ-021 INIT_REQ during SWEEP SHALL restart the sweep at address 0; INIT_REQ in IDLE SHALL enter SWEEP next cycle and block physics grant in its own cycle.
REQ-022 Priority per cycle SHALL be SWEEP > R_EN > P_REQ; physics granted only in IDLE with R_EN low and INIT_REQ low.
REQ-023 During SWEEP, R_ALIVE SHALL read 0 and P_GNT SHALL stay low; pending P_REQ is serviced after sweep.
REQ-024 Renderer read latency SHALL be exactly 1 cycle; R_ALIVE holds last value when R_EN low.
REQ-025 On P_GNT with P_WE=1 and brick alive: bit cleared, ALIVE_COUNT decremented next cycle; brick already dead: no change.
REQ-026 P_ALIVE SHALL report the bit value before the granted access.
REQ-027 Addresses >= NUM_BLOCKS SHALL read 0, ignore writes, and still complete handshakes normally.
REQ-028 LEVEL_CLEAR SHALL pulse the cycle ALIVE_COUNT becomes 0 via a kill; never from reset or sweep.
REQ-029 Requester changing P_ADDR/P_WE while P_REQ high and ungranted is illegal; the bench SHALL flag it as an assertion.

Reset
REQ-030 RESET_N low SHALL asynchronously force: R_ALIVE, P_GNT, P_VALID, P_ALIVE, LEVEL_CLEAR = 0; ALIVE_COUNT = 0; BUSY = 1; FSM = SWEEP at address 0.
REQ-031 Reset asserted mid-sweep or mid-handshake SHALL abandon the operation; the sweep restarts from 0 on release.
REQ-032 Storage contents need not be reset; the sweep defines them.

Structure
REQ-033 NUM_BLOCKS default, ADDR_W and FSM state enum SHALL reside in shared package breakout_pkg.
REQ-034 The alive-bit store SHALL be sub-module block_alive_mem (1-port, synchronous read, write-enable); arbitration, FSM and counter stay in block_ram_arbiter.

Verification
REQ-035 Reset release: BUSY high 96 cycles, then low; ALIVE_COUNT = 96; read of addr 5 returns R_ALIVE=1.
REQ-036 P_REQ kill addr 10 with R_EN held high 3 cycles: P_GNT on cycle 4, P_VALID/P_ALIVE=1 cycle 5, ALIVE_COUNT = 95, later read of 10 returns 0.
REQ-037 Kill addr 10 twice: second P_ALIVE=0, ALIVE_COUNT stays 95.
REQ-038 Kill all 96 bricks: LEVEL_CLEAR single pulse with ALIVE_COUNT 1->0; INIT_REQ then restores 96 with no LEVEL_CLEAR.
REQ-039 INIT_REQ at sweep address 50: sweep restarts at 0, BUSY lasts 96 further cycles; P_REQ pending throughout granted first cycle after BUSY falls.
REQ-040 Read and kill of addr 120: R_ALIVE=0, P_ALIVE=0, handshake completes, ALIVE_COUNT unchanged.
